// File: rtl/servo_seq_multi.sv
// servo_seq_multi: multi-channel servo PWM generator with per-channel angle tables
// and a wrap/ping-pong sweep sequencer, all timed from the single system clock.
module servo_seq_multi #(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 10000,
    parameter int DWELL_HZ     = 10,
    parameter int PERIOD_TICKS = 200,
    parameter int NCH          = 2,
    parameter int DEPTH        = 4,
    parameter int WW           = 8,
    parameter int SPW          = 3,
    parameter int W_MIN        = 5,
    parameter int W_MAX        = 25,
    parameter int W_DEF        = 15,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] enable,
    input  logic           mode,
    input  logic           hold,
    input  logic           speed_up,
    input  logic           speed_dn,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [IW-1:0]  wr_idx,
    input  logic [WW-1:0]  wr_data,
    output logic [NCH-1:0] pwm_out,
    output logic           frame_start,
    output logic [IW-1:0]  idx,
    output logic [SPW-1:0] speed
);
    localparam int PRE = CLK_HZ / TICK_HZ;
    localparam int DWD = TICK_HZ / DWELL_HZ;
    localparam int PRW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int DWW = (DWD > 1) ? $clog2(DWD) : 1;
    localparam int PTW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

    typedef enum logic {DWELL, STEP} state_t;

    state_t          state_q, state_d;
    logic [PRW-1:0]  pre_q, pre_d;
    logic [DWW-1:0]  dpre_q, dpre_d;
    logic [PTW-1:0]  period_q, period_d;
    logic [WW-1:0]   table_q [NCH][DEPTH];
    logic [WW-1:0]   table_d [NCH][DEPTH];
    logic [WW-1:0]   width_q [NCH];
    logic [WW-1:0]   width_d [NCH];
    logic [NCH-1:0]  pwm_q, pwm_d;
    logic            frame_start_q, frame_start_d;
    logic            up_q, up_d, dn_q, dn_d;
    logic [SPW-1:0]  speed_q, speed_d;
    logic [SPW:0]    dcnt_q, dcnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            dir_dn_q, dir_dn_d;
    logic            tick, dwell_tick, frame_tick, up_rise, dn_rise, go_up, at_limit;

    function automatic logic [WW-1:0] clamp(input logic [WW-1:0] w);
        return (w < WW'(W_MIN)) ? WW'(W_MIN) : (w > WW'(W_MAX)) ? WW'(W_MAX) : w;
    endfunction

    always_comb begin
        tick       = pre_q == PRW'(PRE - 1);
        dwell_tick = tick && dpre_q == DWW'(DWD - 1);
        frame_tick = tick && period_q == PTW'(PERIOD_TICKS - 1);
        pre_d      = tick ? '0 : pre_q + 1'b1;
        dpre_d     = dwell_tick ? '0 : tick ? dpre_q + 1'b1 : dpre_q;
        period_d   = frame_tick ? '0 : tick ? period_q + 1'b1 : period_q;
        frame_start_d = frame_tick;
    end

    // Widths are only sampled at frame start, so mid-frame edits never glitch a pulse.
    always_comb begin
        table_d = table_q;
        width_d = width_q;
        pwm_d   = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int d = 0; d < DEPTH; d++)
                if (wr_en && wr_ch == CW'(c) && wr_idx == IW'(d)) table_d[c][d] = wr_data;
            width_d[c] = frame_tick ? clamp(table_q[c][idx_q]) : width_q[c];
            pwm_d[c]   = enable[c] && (int'(period_q) < int'(width_q[c]));
        end
    end

    always_comb begin
        up_d    = speed_up;
        dn_d    = speed_dn;
        up_rise = speed_up && !up_q;
        dn_rise = speed_dn && !dn_q;
        speed_d = (up_rise && !dn_rise && speed_q != '1) ? speed_q + 1'b1 :
                  (dn_rise && !up_rise && speed_q != '0) ? speed_q - 1'b1 : speed_q;
    end

    // Dwell limit is 2*(speed+1)-1; a lowered speed can leave the count above it.
    always_comb begin
        at_limit = dcnt_q >= {speed_q, 1'b1};
        state_d  = (state_q == STEP) ? DWELL : (dwell_tick && !hold && at_limit) ? STEP : DWELL;
    end

    always_comb begin
        go_up    = !mode || (dir_dn_q ? idx_q == '0 : idx_q != IW'(DEPTH - 1));
        dcnt_d   = (state_q == STEP) ? '0 :
                   (dwell_tick && !hold && !at_limit) ? dcnt_q + 1'b1 : dcnt_q;
        idx_d    = (state_q != STEP) ? idx_q :
                   (DEPTH == 1) ? '0 :
                   go_up ? ((idx_q == IW'(DEPTH - 1)) ? '0 : idx_q + 1'b1) : idx_q - 1'b1;
        dir_dn_d = (state_q == STEP) ? !go_up : dir_dn_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= DWELL;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q         <= '0;
            dpre_q        <= '0;
            period_q      <= PTW'(PERIOD_TICKS - 1);
            table_q       <= '{default: '{default: WW'(W_DEF)}};
            width_q       <= '{default: '0};
            pwm_q         <= '0;
            frame_start_q <= 1'b0;
            up_q          <= 1'b0;
            dn_q          <= 1'b0;
            speed_q       <= '0;
            dcnt_q        <= '0;
            idx_q         <= '0;
            dir_dn_q      <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            dpre_q        <= dpre_d;
            period_q      <= period_d;
            table_q       <= table_d;
            width_q       <= width_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            up_q          <= up_d;
            dn_q          <= dn_d;
            speed_q       <= speed_d;
            dcnt_q        <= dcnt_d;
            idx_q         <= idx_d;
            dir_dn_q      <= dir_dn_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;
    assign idx         = idx_q;
    assign speed       = speed_q;
endmodule

// File: tb/tb_servo_seq_multi.sv
// tb_servo_seq_multi: scoreboard bench for servo_seq_multi; 10 clk per tick,
// 200 clk per frame, 100 clk per dwell tick.
module tb_servo_seq_multi;
    localparam int FRAME = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] enable = 2'b11;
    logic       mode = 1'b0, hold = 1'b0, speed_up = 1'b0, speed_dn = 1'b0, wr_en = 1'b0;
    logic       wr_ch = 1'b0;
    logic [1:0] wr_idx = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] pwm_out;
    logic       frame_start;
    logic [1:0] idx;
    logic [2:0] speed;

    int checks = 0, passes = 0, cyc = 0;
    typedef struct {int idx; int h0; int h1;} exp_t;
    exp_t sb[$];

    servo_seq_multi #(
        .CLK_HZ(100), .TICK_HZ(10), .DWELL_HZ(1), .PERIOD_TICKS(20), .NCH(2), .DEPTH(4),
        .WW(8), .SPW(3), .W_MIN(2), .W_MAX(18), .W_DEF(10)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .hold(hold),
        .speed_up(speed_up), .speed_dn(speed_dn), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_idx(wr_idx), .wr_data(wr_data), .pwm_out(pwm_out), .frame_start(frame_start),
        .idx(idx), .speed(speed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= reset ? cyc + 1 : 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b0; enable = 2'b11; mode = 1'b0; hold = 1'b0;
        speed_up = 1'b0; speed_dn = 1'b0; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int d, input int w);
        wr_en = 1'b1; wr_ch = 1'(ch); wr_idx = 2'(d); wr_data = 8'(w);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse(input bit up, input bit dn);
        speed_up = up; speed_dn = dn;
        @(negedge clk);
        speed_up = 1'b0; speed_dn = 1'b0;
        @(negedge clk);
    endtask

    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = frame_start;
        end
    endtask

    task automatic measure(output int i_s, output int h0, output int h1, output bit fs);
        i_s = int'(idx); h0 = 0; h1 = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
        end
        fs = frame_start;
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 2'b11;
        repeat (2) @(negedge clk);
        checks++; if (pwm_out !== 2'b00) $display("FAIL rst_pwm: got %b want 00", pwm_out); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL rst_fs: got %b want 0", frame_start); else passes++;
        checks++; if (idx !== 2'd0) $display("FAIL rst_idx: got %0d want 0", idx); else passes++;
        checks++; if (speed !== 3'd0) $display("FAIL rst_speed: got %0d want 0", speed); else passes++;
        reset = 1'b1;
        wait_cyc(5);
        checks++; if (pwm_out !== 2'b00) $display("FAIL pre_frame_pwm: got %b want 00", pwm_out); else passes++;
        wait_cyc(9);
        checks++; if (frame_start !== 1'b0) $display("FAIL fs_early: got %b want 0", frame_start); else passes++;
        wait_cyc(10);
        checks++; if (frame_start !== 1'b1) $display("FAIL fs_first: got %b want 1", frame_start); else passes++;
        wait_cyc(15);
        checks++; if (pwm_out !== 2'b11) $display("FAIL first_pulse: got %b want 11", pwm_out); else passes++;
    endtask

    task automatic test_default();
        bit ok, fs; int i_s, h0, h1; exp_t e;
        do_reset();
        for (int f = 0; f < 2; f++) sb.push_back('{f, 100, 100});
        sync_frame(ok);
        checks++; if (!ok) $display("FAIL def_sync: got no frame_start want one"); else passes++;
        for (int f = 0; f < 2; f++) begin
            measure(i_s, h0, h1, fs); e = sb.pop_front();
            checks++; if (i_s !== e.idx) $display("FAIL def_idx f%0d: got %0d want %0d", f, i_s, e.idx); else passes++;
            checks++; if (h0 !== e.h0) $display("FAIL def_h0 f%0d: got %0d want %0d", f, h0, e.h0); else passes++;
            checks++; if (h1 !== e.h1) $display("FAIL def_h1 f%0d: got %0d want %0d", f, h1, e.h1); else passes++;
            checks++; if (fs !== 1'b1) $display("FAIL def_period f%0d: got %b want 1", f, fs); else passes++;
        end
    endtask

    task automatic test_wrap();
        bit ok, fs; int i_s, h0, h1; exp_t e;
        int ex_idx[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int d = 0; d < 4; d++) wr(0, d, 4 * (d + 1));
        for (int f = 0; f < 5; f++) sb.push_back('{ex_idx[f], 40 * (ex_idx[f] + 1), 100});
        sync_frame(ok);
        checks++; if (!ok) $display("FAIL wrap_sync: got no frame_start want one"); else passes++;
        for (int f = 0; f < 5; f++) begin
            measure(i_s, h0, h1, fs); e = sb.pop_front();
            checks++; if (i_s !== e.idx) $display("FAIL wrap_idx f%0d: got %0d want %0d", f, i_s, e.idx); else passes++;
            checks++; if (h0 !== e.h0) $display("FAIL wrap_h0 f%0d: got %0d want %0d", f, h0, e.h0); else passes++;
            checks++; if (h1 !== e.h1) $display("FAIL wrap_h1 f%0d: got %0d want %0d", f, h1, e.h1); else passes++;
            checks++; if (fs !== 1'b1) $display("FAIL wrap_period f%0d: got %b want 1", f, fs); else passes++;
        end
    endtask

    task automatic test_pingpong();
        bit ok, fs; int i_s, h0, h1; exp_t e;
        int ex_idx[7] = '{0, 1, 2, 3, 2, 1, 0};
        int w0[4] = '{20, 80, 120, 180};
        do_reset();
        mode = 1'b1;
        wr(0, 0, 0); wr(0, 1, 8); wr(0, 2, 12); wr(0, 3, 30); wr(1, 0, 1);
        for (int f = 0; f < 7; f++)
            sb.push_back('{ex_idx[f], w0[ex_idx[f]], (ex_idx[f] == 0) ? 20 : 100});
        sync_frame(ok);
        checks++; if (!ok) $display("FAIL pp_sync: got no frame_start want one"); else passes++;
        for (int f = 0; f < 7; f++) begin
            measure(i_s, h0, h1, fs); e = sb.pop_front();
            checks++; if (i_s !== e.idx) $display("FAIL pp_idx f%0d: got %0d want %0d", f, i_s, e.idx); else passes++;
            checks++; if (h0 !== e.h0) $display("FAIL pp_h0 f%0d: got %0d want %0d", f, h0, e.h0); else passes++;
            checks++; if (h1 !== e.h1) $display("FAIL pp_h1 f%0d: got %0d want %0d", f, h1, e.h1); else passes++;
            checks++; if (fs !== 1'b1) $display("FAIL pp_period f%0d: got %b want 1", f, fs); else passes++;
        end
    endtask

    task automatic test_midframe_write();
        bit ok, fs; int i_s, h0, h1; exp_t e;
        do_reset();
        sb.push_back('{0, 100, 100});
        sb.push_back('{1, 60, 100});
        sb.push_back('{2, 100, 100});
        sync_frame(ok);
        checks++; if (!ok) $display("FAIL mid_sync: got no frame_start want one"); else passes++;
        for (int f = 0; f < 3; f++) begin
            if (f == 0) begin
                fork
                    measure(i_s, h0, h1, fs);
                    begin wait_cyc(50); wr(0, 0, 4); wr(0, 1, 6); end
                join
            end else measure(i_s, h0, h1, fs);
            e = sb.pop_front();
            checks++; if (i_s !== e.idx) $display("FAIL mid_idx f%0d: got %0d want %0d", f, i_s, e.idx); else passes++;
            checks++; if (h0 !== e.h0) $display("FAIL mid_h0 f%0d: got %0d want %0d", f, h0, e.h0); else passes++;
            checks++; if (h1 !== e.h1) $display("FAIL mid_h1 f%0d: got %0d want %0d", f, h1, e.h1); else passes++;
        end
    endtask

    task automatic test_speed_sat();
        do_reset();
        pulse(1, 0);
        checks++; if (speed !== 3'd1) $display("FAIL spd_one: got %0d want 1", speed); else passes++;
        repeat (8) pulse(1, 0);
        checks++; if (speed !== 3'd7) $display("FAIL spd_sat: got %0d want 7", speed); else passes++;
        pulse(1, 1);
        checks++; if (speed !== 3'd7) $display("FAIL spd_both: got %0d want 7", speed); else passes++;
        wait_cyc(1590);
        checks++; if (idx !== 2'd0) $display("FAIL spd_dwell_early: got %0d want 0", idx); else passes++;
        wait_cyc(1610);
        checks++; if (idx !== 2'd1) $display("FAIL spd_dwell_step: got %0d want 1", idx); else passes++;
        repeat (8) pulse(0, 1);
        checks++; if (speed !== 3'd0) $display("FAIL spd_floor: got %0d want 0", speed); else passes++;
    endtask

    task automatic test_speed_limit();
        do_reset();
        repeat (7) pulse(1, 0);
        wait_cyc(550);
        repeat (7) pulse(0, 1);
        checks++; if (speed !== 3'd0) $display("FAIL lim_speed: got %0d want 0", speed); else passes++;
        wait_cyc(595);
        checks++; if (idx !== 2'd0) $display("FAIL lim_early: got %0d want 0", idx); else passes++;
        wait_cyc(605);
        checks++; if (idx !== 2'd1) $display("FAIL lim_step: got %0d want 1", idx); else passes++;
    endtask

    task automatic test_hold();
        do_reset();
        wait_cyc(150);
        hold = 1'b1;
        wait_cyc(415);
        checks++; if (pwm_out !== 2'b11) $display("FAIL hold_pwm: got %b want 11", pwm_out); else passes++;
        wait_cyc(650);
        checks++; if (idx !== 2'd0) $display("FAIL hold_idx: got %0d want 0", idx); else passes++;
        hold = 1'b0;
        wait_cyc(695);
        checks++; if (idx !== 2'd0) $display("FAIL hold_resume_early: got %0d want 0", idx); else passes++;
        wait_cyc(705);
        checks++; if (idx !== 2'd1) $display("FAIL hold_resume_step: got %0d want 1", idx); else passes++;
    endtask

    task automatic test_enable_reset();
        do_reset();
        wait_cyc(50);
        checks++; if (pwm_out !== 2'b11) $display("FAIL en_both: got %b want 11", pwm_out); else passes++;
        enable = 2'b01;
        wait_cyc(51);
        checks++; if (pwm_out !== 2'b01) $display("FAIL en_drop: got %b want 01", pwm_out); else passes++;
        pulse(1, 0);
        wait_cyc(420);
        checks++; if (idx !== 2'd1) $display("FAIL en_pre_idx: got %0d want 1", idx); else passes++;
        checks++; if (speed !== 3'd1) $display("FAIL en_pre_speed: got %0d want 1", speed); else passes++;
        checks++; if (pwm_out !== 2'b01) $display("FAIL en_pre_pwm: got %b want 01", pwm_out); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (pwm_out !== 2'b00) $display("FAIL arst_pwm: got %b want 00", pwm_out); else passes++;
        checks++; if (idx !== 2'd0) $display("FAIL arst_idx: got %0d want 0", idx); else passes++;
        checks++; if (speed !== 3'd0) $display("FAIL arst_speed: got %0d want 0", speed); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL arst_fs: got %b want 0", frame_start); else passes++;
    endtask

    initial begin
        test_reset();
        test_default();
        test_wrap();
        test_pingpong();
        test_midframe_write();
        test_speed_sat();
        test_speed_limit();
        test_hold();
        test_enable_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
